// File: rtl/ips2l_uart_32bit_pkg.sv
// ips2l_uart_32bit_pkg: shared state encoding and word/byte geometry for the UART word scheduler
package ips2l_uart_32bit_pkg;
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      GAP  = 2'd2
   } state_t;
   localparam int BYTES_PER_WORD = 4;
   localparam int BYTE_W = 8;
   localparam int WORD_W = BYTE_W * BYTES_PER_WORD;
   localparam int CNT_W = 2;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BYTES_PER_WORD - 1);
endpackage

// File: rtl/ips2l_rr_arb2.sv
// ips2l_rr_arb2: two-requester round-robin arbiter, rr names the requester preferred on contention
module ips2l_rr_arb2 (
   input  logic [1:0] valid,
   input  logic       rr,
   input  logic       en,
   output logic [1:0] grant
);
   assign grant[0] = en & valid[0] & (~valid[1] | ~rr);
   assign grant[1] = en & valid[1] & (~valid[0] | rr);
endmodule

// File: rtl/ips2l_uart_word_sched_32bit.sv
// ips2l_uart_word_sched_32bit: round-robin 32-bit word scheduler serialising onto a byte UART; IPS2L_UART_WORD_GAP_EN adds baud-tick spacing between words
module ips2l_uart_word_sched_32bit
   import ips2l_uart_32bit_pkg::*;
#(
   parameter int MSB_FIRST = 0,
   parameter int GAP_TICKS = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clk_en,
   input  logic                req0_valid,
   input  logic [WORD_W-1:0]   req0_data,
   output logic                req0_ready,
   input  logic                req1_valid,
   input  logic [WORD_W-1:0]   req1_data,
   output logic                req1_ready,
   output logic [BYTE_W-1:0]   tx_data,
   output logic                tx_valid,
   input  logic                tx_ready,
   output logic                busy,
   output logic                grant_id
);
   state_t            state;
   logic [WORD_W-1:0] sreg;
   logic [CNT_W-1:0]  cnt;
   logic              rr;
   logic [1:0]        grant;
`ifdef IPS2L_UART_WORD_GAP_EN
   logic [7:0]        gap_cnt;
`else
   logic              unused_gap_cfg;
   assign unused_gap_cfg = clk_en ^ (GAP_TICKS != 0);
`endif

   ips2l_rr_arb2 u_arb (
      .valid ({req1_valid, req0_valid}),
      .rr    (rr),
      .en    (state == IDLE),
      .grant (grant)
   );

   assign req0_ready = grant[0];
   assign req1_ready = grant[1];
   assign busy       = (state != IDLE);
   assign tx_data    = (MSB_FIRST != 0) ? sreg[WORD_W-1 -: BYTE_W] : sreg[BYTE_W-1:0];

   // capture the granted word, shift out one byte per accepted handshake, then pace or return to idle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         sreg     <= '0;
         cnt      <= '0;
         rr       <= 1'b0;
         grant_id <= 1'b0;
         tx_valid <= 1'b0;
`ifdef IPS2L_UART_WORD_GAP_EN
         gap_cnt  <= '0;
`endif
      end else begin
         case (state)
            IDLE: if (|grant) begin
               sreg     <= grant[1] ? req1_data : req0_data;
               grant_id <= grant[1];
               rr       <= ~grant[1];
               tx_valid <= 1'b1;
               state    <= SEND;
            end
            SEND: if (tx_valid && tx_ready) begin
               if (cnt != CNT_LAST) begin
                  sreg <= (MSB_FIRST != 0) ? sreg << BYTE_W : sreg >> BYTE_W;
                  cnt  <= cnt + 1'b1;
               end else begin
                  tx_valid <= 1'b0;
                  cnt      <= '0;
`ifdef IPS2L_UART_WORD_GAP_EN
                  gap_cnt  <= 8'(GAP_TICKS);
                  state    <= (GAP_TICKS != 0) ? GAP : IDLE;
`else
                  state    <= IDLE;
`endif
               end
            end
`ifdef IPS2L_UART_WORD_GAP_EN
            GAP: begin
               if (gap_cnt == 8'd0) state <= IDLE;
               else if (clk_en) gap_cnt <= gap_cnt - 8'd1;
            end
`endif
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ips2l_uart_word_sched_32bit.sv
// tb_ips2l_uart_word_sched_32bit: directed self-checking bench for the UART word scheduler
module tb_ips2l_uart_word_sched_32bit;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        clk_en = 1'b0;
   logic        req0_valid = 1'b0;
   logic [31:0] req0_data = '0;
   logic        req0_ready;
   logic        req1_valid = 1'b0;
   logic [31:0] req1_data = '0;
   logic        req1_ready;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready = 1'b0;
   logic        busy;
   logic        grant_id;
   int checks = 0;
   int failures = 0;

   ips2l_uart_word_sched_32bit #(.MSB_FIRST(0), .GAP_TICKS(3)) dut (
      .clk        (clk),
      .rst        (rst),
      .clk_en     (clk_en),
      .req0_valid (req0_valid),
      .req0_data  (req0_data),
      .req0_ready (req0_ready),
      .req1_valid (req1_valid),
      .req1_data  (req1_data),
      .req1_ready (req1_ready),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .busy       (busy),
      .grant_id   (grant_id)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic wait_idle();
      for (int n = 0; n < 40 && busy; n++) step();
      chk("idle_timeout", {31'd0, busy}, 32'd0);
   endtask

   task automatic wait_ready();
      for (int n = 0; n < 40 && !(req0_ready | req1_ready); n++) step();
      chk("ready_timeout", {31'd0, req0_ready | req1_ready}, 32'd1);
   endtask

   initial begin
      logic [7:0] bytes_a [4];
      int k;
      #2;
      chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
      chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_grant_id", {31'd0, grant_id}, 32'd0);
      step();
      rst = 1'b0;
      step();

      // single word, LSB byte first
      tx_ready = 1'b1;
      req0_valid = 1'b1;
      req0_data = 32'hA1B2C3D4;
      #1;
      chk("single_r0_ready", {31'd0, req0_ready}, 32'd1);
      chk("single_r1_ready", {31'd0, req1_ready}, 32'd0);
      step();
      req0_valid = 1'b0;
      chk("single_valid_lat1", {31'd0, tx_valid}, 32'd1);
      chk("single_busy", {31'd0, busy}, 32'd1);
      bytes_a = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("single_b%0d", i), {24'd0, tx_data}, {24'd0, bytes_a[i]});
         chk($sformatf("single_v%0d", i), {31'd0, tx_valid}, 32'd1);
         step();
      end
      chk("single_valid_drop", {31'd0, tx_valid}, 32'd0);
      chk("single_busy_drop", {31'd0, busy}, 32'd0);

      // contention from reset: strict alternation 0,1,0,1
      rst = 1'b1;
      #1;
      rst = 1'b0;
      req0_valid = 1'b1;
      req0_data = 32'h11111111;
      req1_valid = 1'b1;
      req1_data = 32'h22222222;
      #1;
      for (int g = 0; g < 4; g++) begin
         wait_ready();
         chk($sformatf("cont_r0_ready%0d", g), {31'd0, req0_ready}, {31'd0, g % 2 == 0});
         chk($sformatf("cont_r1_ready%0d", g), {31'd0, req1_ready}, {31'd0, g % 2 == 1});
         step();
         chk($sformatf("cont_grant%0d", g), {31'd0, grant_id}, 32'(g % 2));
         chk($sformatf("cont_byte0_%0d", g), {24'd0, tx_data}, (g % 2 == 1) ? 32'h22 : 32'h11);
         chk($sformatf("cont_send_noready%0d", g), {31'd0, req0_ready | req1_ready}, 32'd0);
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      wait_idle();

      // backpressure on byte 2
      req0_valid = 1'b1;
      req0_data = 32'hCAFEF00D;
      step();
      req0_valid = 1'b0;
      chk("bp_b0", {24'd0, tx_data}, 32'h0D);
      step();
      chk("bp_b1", {24'd0, tx_data}, 32'hF0);
      step();
      tx_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         chk($sformatf("bp_hold_data%0d", i), {24'd0, tx_data}, 32'hFE);
         chk($sformatf("bp_hold_valid%0d", i), {31'd0, tx_valid}, 32'd1);
      end
      tx_ready = 1'b1;
      step();
      chk("bp_b3", {24'd0, tx_data}, 32'hCA);
      chk("bp_b3_valid", {31'd0, tx_valid}, 32'd1);
      step();
      chk("bp_done", {31'd0, tx_valid}, 32'd0);

      // two queued words: spacing between the first word's end and the second handshake
      req0_valid = 1'b1;
      req0_data = 32'h01020304;
      step();
      req0_valid = 1'b0;
      req1_valid = 1'b1;
      req1_data = 32'h05060708;
      for (int i = 0; i < 4; i++) step();
      chk("gap_first_drop", {31'd0, tx_valid}, 32'd0);
      k = 0;
      while (k < 60 && !tx_valid) begin
         k++;
         clk_en = (k % 10 == 0);
         step();
      end
      clk_en = 1'b0;
      req1_valid = 1'b0;
`ifdef IPS2L_UART_WORD_GAP_EN
      chk("gap_second_hs_cycle", 32'(k), 32'd32);
`else
      chk("nogap_second_hs_cycle", 32'(k), 32'd1);
`endif
      chk("gap_second_grant", {31'd0, grant_id}, 32'd1);
      chk("gap_second_b0", {24'd0, tx_data}, 32'h08);
      wait_idle();

      // reset mid-word, then a fresh word from byte 0
      req0_valid = 1'b1;
      req0_data = 32'h12345678;
      step();
      req0_valid = 1'b0;
      step();
      chk("rstmid_b1", {24'd0, tx_data}, 32'h56);
      rst = 1'b1;
      #1;
      chk("rstmid_valid", {31'd0, tx_valid}, 32'd0);
      chk("rstmid_busy", {31'd0, busy}, 32'd0);
      step();
      rst = 1'b0;
      req0_valid = 1'b1;
      req0_data = 32'h00000055;
      step();
      req0_valid = 1'b0;
      bytes_a = '{8'h55, 8'h00, 8'h00, 8'h00};
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("fresh_b%0d", i), {24'd0, tx_data}, {24'd0, bytes_a[i]});
         chk($sformatf("fresh_v%0d", i), {31'd0, tx_valid}, 32'd1);
         step();
      end
      chk("fresh_done", {31'd0, tx_valid}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
